// File: rtl/gpio_input_debouncer.sv
// Pin conditioning ahead of the GPIO input path: two-flop synchronizer, then a per-bit debounce counter
// producing clean levels and one-cycle rise/fall strobes. Define GPIO_DEBOUNCE_IRQ_EN for sticky pending bits and irq.
module gpio_input_debouncer #(
   parameter int WIDTH           = 4,
   parameter int CNT_WIDTH       = 20,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [WIDTH-1:0] enable,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   input  logic [WIDTH-1:0] irq_clr,
   output logic             irq
);

   localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [WIDTH-1:0]     sync1;
   logic [WIDTH-1:0]     sync2;
   logic [CNT_WIDTH-1:0] cnt [WIDTH];

   // Pure flop-to-flop path so the first stage has a full cycle to resolve metastability.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pin_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clean_out  <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (!enable[i] || (sync2[i] == clean_out[i])) begin
               cnt[i] <= '0;
            end else if (cnt[i] == TERM_CNT) begin
               // Terminal count: commit the new level and strobe in the same cycle.
               cnt[i]        <= '0;
               clean_out[i]  <= sync2[i];
               rise_pulse[i] <= sync2[i];
               fall_pulse[i] <= ~sync2[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

`ifdef GPIO_DEBOUNCE_IRQ_EN
   logic [WIDTH-1:0] pending;

   // A strobe arriving alongside a clear keeps the bit pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         irq     <= 1'b0;
      end else begin
         pending <= (pending & ~irq_clr) | rise_pulse | fall_pulse;
         irq     <= |pending;
      end
   end
`else
   logic unused_irq_clr;
   assign unused_irq_clr = |irq_clr;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Randomized and directed stimulus for gpio_input_debouncer, scored every cycle against a
// behavioural model that reasons over pin history windows rather than counters.
module tb_gpio_input_debouncer;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int CW = 3;
   localparam int SW = 3 * W + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] pin_in = '0;
   logic [W-1:0] enable = '0;
   logic [W-1:0] irq_clr = '0;
   logic [W-1:0] clean_out;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;
   logic         irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [SW-1:0] exp_q[$];

   // Model state: pins seen at recent edges, and per-edge "enabled and disagreeing" flags.
   logic [W-1:0] pin_hist[$];
   logic [W-1:0] diff_q[$];
   logic [W-1:0] m_clean, m_rise, m_fall, m_pend;
   logic         m_irq;

   gpio_input_debouncer #(
      .WIDTH(W),
      .CNT_WIDTH(CW),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pin_in(pin_in),
      .enable(enable),
      .clean_out(clean_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .irq_clr(irq_clr),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      pin_hist.delete();
      diff_q.delete();
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_pend  = '0;
      m_irq   = 1'b0;
   endtask

   // Behaviour at one rising edge given the inputs applied before it.
   task automatic model_edge(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] c);
      logic [W-1:0] s;
      logic [W-1:0] new_pend;
      logic         new_irq;
      bit           all_set;
      s = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size() - 2] : '0;
      pin_hist.push_back(p);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
`ifdef GPIO_DEBOUNCE_IRQ_EN
      new_pend = (m_pend & ~c) | m_rise | m_fall;
      new_irq  = |m_pend;
`else
      new_pend = '0;
      new_irq  = 1'b0;
`endif
      diff_q.push_back(e & (s ^ m_clean));
      if (diff_q.size() > D) void'(diff_q.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
         all_set = (diff_q.size() == D);
         foreach (diff_q[k]) if (!diff_q[k][i]) all_set = 0;
         if (all_set) begin
            m_clean[i] = s[i];
            m_rise[i]  = s[i];
            m_fall[i]  = ~s[i];
            foreach (diff_q[k]) diff_q[k][i] = 1'b0;
         end
      end
      m_pend = new_pend;
      m_irq  = new_irq;
   endtask

   task automatic step(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] c);
      pin_in  = p;
      enable  = e;
      irq_clr = c;
      model_edge(p, e, c);
      exp_q.push_back({m_irq, m_fall, m_rise, m_clean});
      @(posedge clk);
      @(negedge clk);
      check("scoreboard", {irq, fall_pulse, rise_pulse, clean_out}, exp_q.pop_front());
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      check("reset_now", {irq, fall_pulse, rise_pulse, clean_out}, '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [W-1:0] p, e, c;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", {irq, fall_pulse, rise_pulse, clean_out}, '0);
      reset = 1'b0;

      // Clean step on bit 0: level appears at the 6th edge with a single rise strobe.
      for (int k = 1; k <= 6; k++) begin
         step(4'h1, 4'hF, 4'h0);
         if (k == 5) check("step_early", clean_out, 4'h0);
      end
      check("step_clean", clean_out, 4'h1);
      check("step_rise", rise_pulse, 4'h1);
      check("step_fall", fall_pulse, 4'h0);
      step(4'h1, 4'hF, 4'h0);
      check("step_rise_once", rise_pulse, 4'h0);

      // Three-cycle glitch never reaches the output.
      repeat (3) step(4'h0, 4'hF, 4'h0);
      repeat (8) step(4'h1, 4'hF, 4'h0);
      check("glitch_hold", clean_out, 4'h1);

      // Raise bit 2, then drop it again to see its fall strobe.
      repeat (6) step(4'h5, 4'hF, 4'h0);
      check("bit2_up", clean_out, 4'h5);
      for (int k = 1; k <= 6; k++) step(4'h1, 4'hF, 4'h0);
      check("bit2_fall", fall_pulse, 4'h4);
      check("bit2_down", clean_out, 4'h1);

      // Disabled bit holds; re-enable counts from zero against the held level.
      repeat (20) step(4'h3, 4'hD, 4'h0);
      check("disabled_hold", clean_out, 4'h1);
      for (int k = 1; k <= 3; k++) step(4'h3, 4'hF, 4'h0);
      check("reenable_early", clean_out, 4'h1);
      step(4'h3, 4'hF, 4'h0);
      check("reenable_clean", clean_out, 4'h3);
      check("reenable_rise", rise_pulse, 4'h2);

      // Reset with bits 2/3 mid-count, then a fresh step to all ones.
      repeat (4) step(4'hF, 4'hF, 4'h0);
      apply_reset();
      for (int k = 1; k <= 6; k++) step(4'hF, 4'hF, 4'h0);
      check("post_reset_clean", clean_out, 4'hF);
      check("post_reset_rise", rise_pulse, 4'hF);

`ifdef GPIO_DEBOUNCE_IRQ_EN
      apply_reset();
      for (int k = 1; k <= 6; k++) step(4'h8, 4'hF, 4'h0);
      step(4'h8, 4'hF, 4'h0);
      check("irq_lag", irq, 1'b0);
      step(4'h8, 4'hF, 4'h0);
      check("irq_set", irq, 1'b1);
      for (int k = 1; k <= 6; k++) step(4'h0, 4'hF, 4'h0);
      check("irq_fall_pulse", fall_pulse, 4'h8);
      step(4'h0, 4'hF, 4'h8);
      step(4'h0, 4'hF, 4'h0);
      check("irq_set_wins", irq, 1'b1);
      step(4'h0, 4'hF, 4'h8);
      step(4'h0, 4'hF, 4'h0);
      check("irq_cleared", irq, 1'b0);
`else
      check("irq_tied", irq, 1'b0);
`endif

      // Random phase: slow pin toggling, occasional enable changes, clears and resets.
      p = 4'hF;
      e = 4'hF;
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) p[i] = ~p[i];
         if ($urandom_range(0, 39) == 0) e = 4'($urandom_range(0, 15));
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         if ($urandom_range(0, 299) == 0) apply_reset();
         step(p, e, c);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
